// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I core types and constants for the fetch stage
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int PC_INC = 4;
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory req/gnt/rvalid bus
interface fetch_unit_if;
  import rv32_pkg::*;
  logic req;
  logic [XLEN-1:0] addr;
  logic gnt;
  logic rvalid;
  logic [XLEN-1:0] rdata;
  modport master(output req, addr, input gnt, rvalid, rdata);
  modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc,insn} buffer with flush and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic clk,
  input  logic areset,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge areset)
    if (!areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with redirect flush; IFU_MISALIGN_CHECK_EN adds fetch_misaligned
module fetch_unit import rv32_pkg::*; #(
  parameter int FIFO_DEPTH = 2,
  parameter int PC_INC = rv32_pkg::PC_INC
) (
  input  logic clk,
  input  logic areset,
  input  logic [XLEN-1:0] PC,
  output logic pc_load,
  output logic [XLEN-1:0] PCNext,
  fetch_unit_if.master imem,
  input  logic redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic inst_valid,
  input  logic inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic fetch_misaligned
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state;
  logic live, redir, accept, mis;
  logic [XLEN-1:0] pc_q, target;
  logic [CW-1:0] count;
  logic [2*XLEN-1:0] head;
  assign redir = live & redirect_valid;
`ifdef IFU_MISALIGN_CHECK_EN
  assign mis = fetch_misaligned;
  assign target = redirect_pc;
`else
  assign mis = 1'b0;
  assign target = redirect_pc & ~XLEN'(3);
`endif
  // live keeps every strobe low until the first edge after reset release
  assign imem.req = live && state == FETCH && count < CW'(FIFO_DEPTH) && !redirect_valid && !mis;
  assign imem.addr = imem.req ? PC : '0;
  assign accept = imem.req & imem.gnt;
  assign pc_load = redir | accept;
  assign PCNext = redir ? target : accept ? PC + XLEN'(PC_INC) : '0;
  assign inst_valid = count != '0;
  assign inst_pc = inst_valid ? head[2*XLEN-1:XLEN] : '0;
  assign inst_data = inst_valid ? head[XLEN-1:0] : '0;
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(2*XLEN)) u_fifo (
    .clk(clk),
    .areset(areset),
    .flush(redir),
    .push(state == WAIT && imem.rvalid && !redir),
    .pop(inst_ready),
    .din({pc_q, imem.rdata}),
    .dout(head),
    .count(count)
  );
  always_ff @(posedge clk or negedge areset)
    if (!areset) begin
      state <= FETCH;
      live <= 1'b0;
      pc_q <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
      fetch_misaligned <= 1'b0;
`endif
    end else begin
      live <= 1'b1;
      // a response still owed by memory must be swallowed after a redirect
      if (redir) state <= ((state == FETCH && imem.gnt) || (state != FETCH && !imem.rvalid)) ? DISCARD : FETCH;
      else if (accept) begin
        state <= WAIT;
        pc_q <= PC;
      end else if (state != FETCH && imem.rvalid) state <= FETCH;
`ifdef IFU_MISALIGN_CHECK_EN
      if (redir) fetch_misaligned <= |redirect_pc[1:0];
`endif
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a behavioural memory and PC register
module tb_fetch_unit;
  logic clk = 1'b0;
  logic areset = 1'b0;
  logic [31:0] PC;
  logic pc_load;
  logic [31:0] PCNext;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic inst_valid;
  logic inst_ready = 1'b1;
  logic [31:0] inst_data, inst_pc;
`ifdef IFU_MISALIGN_CHECK_EN
  logic fetch_misaligned;
`endif
  logic gnt_en = 1'b1;
  logic gnt_force = 1'b0;
  int rv_lat = 5;
  logic [31:0] rdata_val = '0;
  logic pend;
  int cnt;
  logic [31:0] pdata;
  logic [63:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk(clk),
    .areset(areset),
    .PC(PC),
    .pc_load(pc_load),
    .PCNext(PCNext),
    .imem(bus),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge areset)
    if (!areset) PC <= '0;
    else if (pc_load) PC <= PCNext;

  assign bus.gnt = gnt_force | (bus.req & gnt_en);

  always_ff @(posedge clk or negedge areset)
    if (!areset) begin
      pend <= 1'b0;
      cnt <= 0;
      pdata <= '0;
      bus.rvalid <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.rvalid <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          bus.rvalid <= 1'b1;
          bus.rdata <= pdata;
          pend <= 1'b0;
        end
        cnt <= cnt - 1;
      end
      if (bus.gnt) begin
        if (rv_lat <= 1) begin
          bus.rvalid <= 1'b1;
          bus.rdata <= rdata_val;
        end else begin
          pend <= 1'b1;
          cnt <= rv_lat - 1;
          pdata <= rdata_val;
        end
      end
    end

  // reference: every accepted fetch will be presented unless a redirect or reset intervenes
  always @(posedge clk or negedge areset)
    if (!areset) exp_q.delete();
    else if (redirect_valid) exp_q.delete();
    else if (bus.req && bus.gnt) exp_q.push_back({PC, rdata_val});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (areset && inst_valid && inst_ready) begin
      logic [63:0] e;
      n_chk++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_empty: observed pc %h data %h expected nothing", inst_pc, inst_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e[63:32]);
        chk("sb_data", inst_data, e[31:0]);
      end
    end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_load(input string tag, input logic [31:0] exp, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pc_load && k < 20);
    chk({tag, "_load"}, 32'(pc_load), 32'd1);
    chk({tag, "_next"}, PCNext, exp);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!inst_valid && k < 20);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int loads;
    // reset, then reset again while a response is outstanding
    tick(2);
    areset = 1'b1;
    tick();
    @(negedge clk);
    chk("first_load", 32'(pc_load), 32'd1);
    tick();
    @(negedge clk);
    chk("wait_noreq", 32'(bus.req), 32'd0);
    tick();
    areset = 1'b0;
    #1;
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_pcnext", PCNext, 32'd0);
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    tick(2);
    rv_lat = 1;
    rdata_val = 32'h0050_0093;
    areset = 1'b1;
    tick();
    @(negedge clk);
    chk("rel_req", 32'(bus.req), 32'd1);
    chk("rel_addr", bus.addr, 32'h0);
    chk("seq_next0", PCNext, 32'h4);
    // sequential stream at one instruction per two cycles
    for (int i = 2; i <= 3; i++) begin
      wait_load("seq", 32'(4 * i), k);
      chk("seq_gap", 32'(k), 32'd2);
    end
    // backpressure fills the buffer and stops fetching
    tick();
    inst_ready = 1'b0;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req", 32'(bus.req), 32'd0);
      chk("bp_valid", 32'(inst_valid), 32'd1);
      chk("bp_pc", inst_pc, 32'h8);
      chk("bp_data", inst_data, 32'h0050_0093);
    end
    tick();
    inst_ready = 1'b1;
    @(negedge clk);
    tick();
    inst_ready = 1'b0;
    loads = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pc_load) loads++;
    end
    chk("bp_one_req", 32'(loads), 32'd1);
    // redirect while a response is in flight
    tick();
    rdata_val = 32'hDEAD_BEEF;
    rv_lat = 3;
    inst_ready = 1'b1;
    @(negedge clk);
    tick();
    inst_ready = 1'b0;
    wait_load("rw_fetch", 32'h18, k);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    rdata_val = 32'h00A0_0113;
    @(negedge clk);
    chk("rw_load", 32'(pc_load), 32'd1);
    chk("rw_next", PCNext, 32'h100);
    chk("rw_req", 32'(bus.req), 32'd0);
    chk("rw_valid_pre", 32'(inst_valid), 32'd1);
    tick();
    redirect_valid = 1'b0;
    rv_lat = 1;
    @(negedge clk);
    chk("rw_flushed", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    wait_load("rw_tgt", 32'h104, k);
    wait_valid("rw_first");
    chk("rw_first_pc", inst_pc, 32'h100);
    chk("rw_first_data", inst_data, 32'h00A0_0113);
    // redirect coincident with a grant while the buffer is full
    tick();
    inst_ready = 1'b0;
    tick(8);
    @(negedge clk);
    chk("full_req", 32'(bus.req), 32'd0);
    tick();
    gnt_force = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    rdata_val = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rg_load", 32'(pc_load), 32'd1);
    chk("rg_next", PCNext, 32'hFFFF_FFFC);
    chk("rg_req", 32'(bus.req), 32'd0);
    tick();
    gnt_force = 1'b0;
    redirect_valid = 1'b0;
    rdata_val = 32'h0010_0073;
    inst_ready = 1'b1;
    wait_load("wrap", 32'h0, k);
    wait_valid("rg_first");
    chk("rg_first_pc", inst_pc, 32'hFFFF_FFFC);
    chk("rg_first_data", inst_data, 32'h0010_0073);
    // misaligned redirect target
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_next", PCNext, 32'h102);
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mis_flag", 32'(fetch_misaligned), 32'd1);
      chk("mis_noreq", 32'(bus.req), 32'd0);
    end
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    chk("mis_fix_next", PCNext, 32'h200);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_clear", 32'(fetch_misaligned), 32'd0);
    wait_load("mis_refetch", 32'h204, k);
`else
    chk("align_next", PCNext, 32'h100);
    tick();
    redirect_valid = 1'b0;
    wait_load("align_refetch", 32'h104, k);
`endif
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
